// File: rtl/decode_rf_stage.sv
// Decode/register-fetch stage: 2R1W register file with write-back bypass,
// immediate extender, RAW/WAW scoreboard and a registered valid/ready output bundle.
module decode_rf_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst,
  // Fetch side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] rs_sel,
  input  logic [REG_AW-1:0] rt_sel,
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic [REG_AW-1:0] wr_sel,
  input  logic              wr_req,
  input  logic [10:0]       imm_raw,
  input  logic [2:0]        imm_mode,
  input  logic              flush,
  // Write-back port
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  // Execute side
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [REG_AW-1:0] wsel_out,
  output logic              wen_out,
  output logic              err
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never waits on ready, and the bundle is frozen while
  // out_valid & !out_ready.

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;

  logic              wb_hit_rs;
  logic              wb_hit_rt;
  logic              wb_hit_wr;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] imm_ext;
  logic              hazard;
  logic              load;

  // Bypass comparisons
  always_comb begin
    wb_hit_rs = wb_en && (wb_sel == rs_sel);
    wb_hit_rt = wb_en && (wb_sel == rt_sel);
    wb_hit_wr = wb_en && (wb_sel == wr_sel);
  end

  always_comb begin
    rs_val = wb_hit_rs ? wb_data : regs[rs_sel];
    rt_val = wb_hit_rt ? wb_data : regs[rt_sel];
  end

  always_comb begin
    imm_ext = '0;
    case (imm_mode)
      3'b000:  imm_ext = {{(DATA_W-5){imm_raw[4]}},   imm_raw[4:0]};
      3'b001:  imm_ext = {{(DATA_W-8){imm_raw[7]}},   imm_raw[7:0]};
      3'b010:  imm_ext = {{(DATA_W-11){imm_raw[10]}}, imm_raw[10:0]};
      3'b011:  imm_ext = {{(DATA_W-5){1'b0}},         imm_raw[4:0]};
      3'b100:  imm_ext = {{(DATA_W-8){1'b0}},         imm_raw[7:0]};
      default: imm_ext = '0;
    endcase
  end

  // A write-back landing this cycle resolves the hazard it would otherwise cause.
  always_comb begin
    hazard = (rs_used && busy[rs_sel] && !wb_hit_rs) ||
             (rt_used && busy[rt_sel] && !wb_hit_rt) ||
             (wr_req  && busy[wr_sel] && !wb_hit_wr);
    in_ready = (!out_valid || out_ready) && !hazard && !flush;
    load     = in_valid && in_ready;
  end

  // Clears first, then the issue-side set so that set wins on a collision.
  always_comb begin
    busy_nxt = busy;
    if (flush && out_valid && wen_out) busy_nxt[wsel_out] = 1'b0;
    if (wb_en)                         busy_nxt[wb_sel]   = 1'b0;
    if (load && wr_req)                busy_nxt[wr_sel]   = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_sel] <= wb_data;
    end
  end

  // Write-back to an idle register is flagged, but the write still happens.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (wb_en && !busy[wb_sel]) begin
      err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      imm_out   <= '0;
      wsel_out  <= '0;
      wen_out   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      a_out     <= rs_val;
      b_out     <= rt_val;
      imm_out   <= imm_ext;
      wsel_out  <= wr_sel;
      wen_out   <= wr_req;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_rf_stage.sv
// Bench for decode_rf_stage: directed scenarios plus random traffic checked
// against an architectural model of registers, pending writes and the output slot.
module tb_decode_rf_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, in_ready;
  logic [2:0]  rs_sel, rt_sel, wr_sel, wb_sel;
  logic        rs_used, rt_used, wr_req, flush, wb_en;
  logic [10:0] imm_raw;
  logic [2:0]  imm_mode;
  logic [15:0] wb_data;
  logic        out_valid, out_ready;
  logic [15:0] a_out, b_out, imm_out;
  logic [2:0]  wsel_out;
  logic        wen_out, err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [15:0] mregs [8];
  bit          mbusy [8];
  bit          mv, mwen, merr;
  logic [15:0] ma, mb, mimm;
  logic [2:0]  mwsel;

  always #5 clk = ~clk;

  decode_rf_stage #(.DATA_W(16), .REG_AW(3), .NREG(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs_sel(rs_sel), .rt_sel(rt_sel), .rs_used(rs_used), .rt_used(rt_used),
    .wr_sel(wr_sel), .wr_req(wr_req), .imm_raw(imm_raw), .imm_mode(imm_mode),
    .flush(flush), .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out), .imm_out(imm_out),
    .wsel_out(wsel_out), .wen_out(wen_out), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Immediate value from field width and signedness, by plain arithmetic.
  function automatic logic [15:0] ref_imm(input logic [10:0] raw, input logic [2:0] mode);
    int n;
    bit sgn;
    int v;
    case (mode)
      3'd0: begin n = 5;  sgn = 1; end
      3'd1: begin n = 8;  sgn = 1; end
      3'd2: begin n = 11; sgn = 1; end
      3'd3: begin n = 5;  sgn = 0; end
      3'd4: begin n = 8;  sgn = 0; end
      default: begin n = 0; sgn = 0; end
    endcase
    if (n == 0) return 16'h0;
    v = int'(raw) & ((1 << n) - 1);
    if (sgn && v >= (1 << (n - 1))) v = v - (1 << n);
    return v[15:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mregs[i] = 16'h0;
      mbusy[i] = 0;
    end
    mv = 0; mwen = 0; merr = 0;
    ma = 16'h0; mb = 16'h0; mimm = 16'h0; mwsel = 3'd0;
  endtask

  task automatic idle();
    in_valid = 0; rs_sel = 0; rt_sel = 0; rs_used = 0; rt_used = 0;
    wr_sel = 0; wr_req = 0; imm_raw = 0; imm_mode = 0; flush = 0;
    wb_en = 0; wb_sel = 0; wb_data = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [2:0] rs, input logic [2:0] rt, input bit ru, input bit tu,
                       input logic [2:0] wr, input bit wreq, input logic [10:0] imm,
                       input logic [2:0] mode);
    in_valid = 1; rs_sel = rs; rt_sel = rt; rs_used = ru; rt_used = tu;
    wr_sel = wr; wr_req = wreq; imm_raw = imm; imm_mode = mode;
  endtask

  // One clock: check in_ready before the edge, advance the model, check outputs after.
  task automatic cycle();
    bit hz, rdy, ld;
    logic [15:0] av, bv;
    @(negedge clk);
    hz = (rs_used && mbusy[rs_sel] && !(wb_en && wb_sel == rs_sel)) ||
         (rt_used && mbusy[rt_sel] && !(wb_en && wb_sel == rt_sel)) ||
         (wr_req  && mbusy[wr_sel] && !(wb_en && wb_sel == wr_sel));
    rdy = (!mv || out_ready) && !hz && !flush;
    chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    @(posedge clk);
    ld = in_valid && rdy;
    av = (wb_en && wb_sel == rs_sel) ? wb_data : mregs[rs_sel];
    bv = (wb_en && wb_sel == rt_sel) ? wb_data : mregs[rt_sel];
    if (wb_en && !mbusy[wb_sel]) merr = 1;
    if (flush && mv && mwen) mbusy[mwsel] = 0;
    if (wb_en) mbusy[wb_sel] = 0;
    if (ld && wr_req) mbusy[wr_sel] = 1;
    if (wb_en) mregs[wb_sel] = wb_data;
    if (flush) mv = 0;
    else if (ld) begin
      mv = 1; ma = av; mb = bv; mimm = ref_imm(imm_raw, imm_mode);
      mwsel = wr_sel; mwen = wr_req;
    end else if (out_ready) mv = 0;
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, mv});
    chk("err", {31'b0, err}, {31'b0, merr});
    if (mv) begin
      chk("a_out", {16'b0, a_out}, {16'b0, ma});
      chk("b_out", {16'b0, b_out}, {16'b0, mb});
      chk("imm_out", {16'b0, imm_out}, {16'b0, mimm});
      chk("wsel_out", {29'b0, wsel_out}, {29'b0, mwsel});
      chk("wen_out", {31'b0, wen_out}, {31'b0, mwen});
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'h0);
    chk({tag, "_a_out"}, {16'b0, a_out}, 32'h0);
    chk({tag, "_b_out"}, {16'b0, b_out}, 32'h0);
    chk({tag, "_imm_out"}, {16'b0, imm_out}, 32'h0);
    chk({tag, "_wsel_out"}, {29'b0, wsel_out}, 32'h0);
    chk({tag, "_wen_out"}, {31'b0, wen_out}, 32'h0);
    chk({tag, "_err"}, {31'b0, err}, 32'h0);
  endtask

  initial begin
    idle();
    model_reset();
    #12;
    check_zero_outputs("reset");
    @(posedge clk); #1 rst = 1;

    // Basic issue: reset-state operands and a negative sext5 immediate
    issue(3'd1, 3'd2, 1, 1, 3'd0, 0, 11'h01F, 3'd0);
    cycle();
    chk("plan1_imm", {16'b0, imm_out}, 32'h0000FFFF);
    idle(); cycle();

    // RAW stall on r3 resolved by write-back bypass
    issue(3'd0, 3'd0, 0, 0, 3'd3, 1, 11'h0, 3'd3);
    cycle();
    issue(3'd3, 3'd1, 1, 1, 3'd0, 0, 11'h005, 3'd3);
    cycle(); cycle();
    wb_en = 1; wb_sel = 3'd3; wb_data = 16'h1234;
    cycle();
    chk("bypass_a", {16'b0, a_out}, 32'h00001234);
    wb_en = 0;
    issue(3'd3, 3'd3, 1, 1, 3'd0, 0, 11'h0, 3'd0);
    cycle();
    idle(); cycle();

    // Back-pressure: bundle holds, then loads on release
    issue(3'd1, 3'd3, 1, 1, 3'd2, 0, 11'h07F, 3'd1);
    cycle();
    out_ready = 0;
    issue(3'd3, 3'd1, 1, 1, 3'd4, 0, 11'h010, 3'd4);
    cycle(); cycle();
    out_ready = 1;
    cycle();
    idle(); cycle();

    // Flush of a pending write to r5 releases its scoreboard entry
    out_ready = 0;
    issue(3'd0, 3'd0, 0, 0, 3'd5, 1, 11'h0, 3'd0);
    cycle();
    idle(); out_ready = 0; flush = 1;
    cycle();
    flush = 0; out_ready = 1;
    issue(3'd5, 3'd0, 1, 0, 3'd0, 0, 11'h0, 3'd0);
    cycle();
    idle(); cycle();

    // Write-back to an idle register: sticky err, data still written
    wb_en = 1; wb_sel = 3'd6; wb_data = 16'hBEEF;
    cycle();
    idle(); cycle();
    issue(3'd6, 3'd6, 1, 1, 3'd0, 0, 11'h0, 3'd0);
    cycle();
    chk("r6_readback", {16'b0, a_out}, 32'h0000BEEF);
    idle(); cycle();

    // Immediate modes
    for (int m = 0; m < 8; m++) begin
      issue(3'd0, 3'd0, 0, 0, 3'd0, 0, 11'h480, m[2:0]);
      cycle();
    end
    idle(); cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      rs_sel    = 3'($urandom_range(0, 7));
      rt_sel    = 3'($urandom_range(0, 7));
      rs_used   = 1'($urandom_range(0, 1));
      rt_used   = 1'($urandom_range(0, 1));
      wr_sel    = 3'($urandom_range(0, 7));
      wr_req    = 1'($urandom_range(0, 1));
      imm_raw   = 11'($urandom_range(0, 2047));
      imm_mode  = 3'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 11) == 0);
      wb_en     = ($urandom_range(0, 2) == 0);
      wb_sel    = 3'($urandom_range(0, 7));
      wb_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    idle();
    for (int r = 0; r < 8; r++) begin
      wb_en = 1; wb_sel = r[2:0]; wb_data = 16'($urandom);
      cycle();
    end
    idle(); cycle();

    // Reset in the middle of a stall clears everything asynchronously
    issue(3'd0, 3'd0, 0, 0, 3'd4, 1, 11'h0, 3'd0);
    cycle();
    issue(3'd4, 3'd0, 1, 0, 3'd1, 0, 11'h3FF, 3'd2);
    cycle();
    #2 rst = 0;
    #1 check_zero_outputs("async_reset");
    model_reset();
    @(posedge clk); #1 rst = 1;
    issue(3'd4, 3'd4, 1, 1, 3'd4, 1, 11'h0, 3'd0);
    cycle();
    idle(); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation exceeded time budget");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
